// File: rtl/programmable_memory.sv
// Parametrised CPU main memory: bus and manual-switch writes, a hardware clear
// sweep, and a streaming loader with a valid/ready handshake.
module programmable_memory #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_from_bus,
    input  logic                  manual_mode,
    input  logic                  manual_read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] program_switches,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    input  logic                  clear_start,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    function automatic logic [DEPTH-1:0][DATA_WIDTH-1:0] power_up_image();
        logic [DEPTH-1:0][DATA_WIDTH-1:0] img;
        logic [4:0][7:0]                  boot;
        boot = {8'h60, 8'hE0, 8'h51, 8'hE0, 8'h58};
        img  = '0;
        for (int k = 0; k < 5 && k < DEPTH; k++) begin
            img[k] = DATA_WIDTH'(boot[k]);
        end
        return img;
    endfunction

    localparam logic [DEPTH-1:0][DATA_WIDTH-1:0] BOOT_IMAGE = power_up_image();

    // Contents are never touched by rst; the boot program is the power-up value.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q = BOOT_IMAGE;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Loader handshake: a beat transfers on a rising edge where load_valid and
    // load_ready are both 1; load_data/load_last are meaningful only then.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = program_switches;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (load_start && manual_mode) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (manual_mode && manual_read) begin
                    mem_we = 1'b1;
                end else if (!manual_mode && read_from_bus) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus_in;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == LAST_ADDR) state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = load_data;
                    ptr_d     = ptr_q + ADDR_WIDTH'(1);
                    count_d   = count_q + (ADDR_WIDTH + 1)'(1);
                    if (load_last) begin
                        state_d = ST_IDLE;
                    end else if (ptr_q == LAST_ADDR) begin
                        ovf_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                // An abort restarts the sweep from word 0, overriding any beat outcome.
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign busy       = (state_q != ST_IDLE);
    assign load_ready = (state_q == ST_LOAD);
    assign load_count = count_q;
    assign overflow   = ovf_q;
    assign dbg_state  = state_q;
    assign bus_out    = busy ? '0 : mem_q[address];

endmodule

// File: tb/tb_programmable_memory.sv
// Self-checking bench for programmable_memory: randomized writes and loads
// compared against a word-array model of the memory contents.
module tb_programmable_memory;
    logic       clk = 1'b0;
    logic       rst;
    logic       read_from_bus, manual_mode, manual_read;
    logic [3:0] address;
    logic [7:0] program_switches, bus_in, bus_out;
    logic       clear_start, load_start, load_valid, load_last, load_ready;
    logic [7:0] load_data;
    logic       busy, overflow;
    logic [4:0] load_count;
    logic [1:0] dbg_state;

    logic [7:0] ref_mem [16];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    programmable_memory dut (
        .clk(clk), .rst(rst), .read_from_bus(read_from_bus), .manual_mode(manual_mode),
        .manual_read(manual_read), .address(address), .program_switches(program_switches),
        .bus_in(bus_in), .bus_out(bus_out), .clear_start(clear_start), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .busy(busy), .load_count(load_count), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        read_from_bus = 0; manual_read = 0; clear_start = 0; load_start = 0;
        load_valid = 0; load_last = 0; load_data = 0; bus_in = 0; program_switches = 0;
    endtask

    task automatic read_word(input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = bus_out;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        manual_mode = 0; address = a; bus_in = d; read_from_bus = 1;
        step();
        read_from_bus = 0;
    endtask

    task automatic start_load();
        manual_mode = 1; load_start = 1;
        step();
        load_start = 0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        load_valid = 1; load_data = d; load_last = last;
        step();
        load_valid = 0; load_last = 0;
    endtask

    task automatic test_reset();
        rst = 1; manual_mode = 0; address = 0;
        idle_inputs();
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", load_ready); end
        n_cmp++; if (load_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", load_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst = 0;
        step();
    endtask

    task automatic test_powerup();
        logic [7:0] d;
        for (int a = 0; a < 16; a++) begin
            read_word(a[3:0], d);
            n_cmp++;
            if (d !== ref_mem[a]) begin n_fail++; $display("FAIL powerup addr %0d: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_direct_write();
        logic [7:0] d;
        logic [3:0] a;
        logic [7:0] sw, bi;
        logic       mm, mr, rb;
        manual_mode = 1; program_switches = 8'hA5; address = 3; manual_read = 1;
        step();
        manual_read = 0; ref_mem[3] = 8'hA5;
        read_word(4'd3, d);
        n_cmp++; if (d !== 8'hA5) begin n_fail++; $display("FAIL manual_write: got %h want a5", d); end
        bus_write(4'd3, 8'h3C); ref_mem[3] = 8'h3C;
        read_word(4'd3, d);
        n_cmp++; if (d !== 8'h3C) begin n_fail++; $display("FAIL bus_write: got %h want 3c", d); end
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom_range(0, 15)); sw = 8'($urandom); bi = 8'($urandom);
            mm = 1'($urandom); mr = 1'($urandom); rb = 1'($urandom);
            manual_mode = mm; address = a; program_switches = sw; bus_in = bi;
            manual_read = mr; read_from_bus = rb;
            step();
            manual_read = 0; read_from_bus = 0;
            if (mm && mr) ref_mem[a] = sw;
            else if (!mm && rb) ref_mem[a] = bi;
            read_word(a, d);
            n_cmp++;
            if (d !== ref_mem[a]) begin n_fail++; $display("FAIL random_write addr %0d: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic fill_random();
        logic [7:0] v;
        for (int a = 0; a < 16; a++) begin
            v = 8'($urandom_range(1, 255));
            bus_write(a[3:0], v);
            ref_mem[a] = v;
        end
    endtask

    task automatic test_clear();
        logic [7:0] d;
        int cycles;
        manual_mode = 0; clear_start = 1;
        step();
        clear_start = 0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            address = 7; bus_in = 8'hFF; read_from_bus = (cycles == 3);
            if (cycles == 5) begin
                #1;
                n_cmp++; if (bus_out !== 8'h00) begin n_fail++; $display("FAIL clear_bus_out_hidden: got %h want 00", bus_out); end
            end
            step();
        end
        read_from_bus = 0;
        n_cmp++; if (cycles != 16) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d want 16", cycles); end
        for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
        for (int a = 0; a < 16; a++) begin
            read_word(a[3:0], d);
            n_cmp++;
            if (d !== ref_mem[a]) begin n_fail++; $display("FAIL clear_word %0d: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_load_backpressure();
        logic [7:0] d;
        logic [7:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        start_load();
        n_cmp++; if (load_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL load_start: got ready=%b busy=%b want 1/1", load_ready, busy); end
        for (int i = 0; i < 3; i++) begin
            send_beat(beats[i], i == 2);
            if (i < 2) begin
                n_cmp++; if (load_count !== 5'(i + 1)) begin n_fail++; $display("FAIL load_count_mid: got %0d want %0d", load_count, i + 1); end
                // A mode change and a bus write during the gap must neither abort nor write.
                manual_mode = 0; address = 9; bus_in = 8'hEE; read_from_bus = 1;
                step();
                read_from_bus = 0;
                step();
                n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_gap_ready: got %b want 1", load_ready); end
            end
        end
        for (int i = 0; i < 3; i++) ref_mem[i] = beats[i];
        n_cmp++; if (load_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL load_end: got ready=%b busy=%b want 0/0", load_ready, busy); end
        n_cmp++; if (load_count !== 5'd3) begin n_fail++; $display("FAIL load_count: got %0d want 3", load_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL load_overflow: got %b want 0", overflow); end
        for (int a = 0; a < 16; a++) begin
            read_word(a[3:0], d);
            n_cmp++;
            if (d !== ref_mem[a]) begin n_fail++; $display("FAIL load_word %0d: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_load_random();
        logic [7:0] d;
        logic [7:0] beats [$];
        int len;
        len = $urandom_range(1, 15);
        for (int i = 0; i < len; i++) beats.push_back(8'($urandom));
        // A manual strobe in the start cycle must not write word 15.
        manual_mode = 1; load_start = 1; manual_read = 1; address = 15; program_switches = 8'h77;
        step();
        load_start = 0; manual_read = 0;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send_beat(beats[i], i == len - 1);
        end
        for (int i = 0; i < len; i++) ref_mem[i] = beats[i];
        n_cmp++; if (load_count !== 5'(len)) begin n_fail++; $display("FAIL rand_load_count: got %0d want %0d", load_count, len); end
        n_cmp++; if (busy !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rand_load_end: got busy=%b ovf=%b want 0/0", busy, overflow); end
        for (int a = 0; a < 16; a++) begin
            read_word(a[3:0], d);
            n_cmp++;
            if (d !== ref_mem[a]) begin n_fail++; $display("FAIL rand_load_word %0d: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_load_overflow();
        logic [7:0] d;
        logic [7:0] v;
        for (int pass = 0; pass < 2; pass++) begin
            start_load();
            n_cmp++; if (overflow !== 1'b0 || load_count !== 5'd0) begin n_fail++; $display("FAIL ovf_start_clear: got ovf=%b count=%0d want 0/0", overflow, load_count); end
            for (int i = 0; i < 16; i++) begin
                v = 8'($urandom);
                ref_mem[i] = v;
                send_beat(v, (pass == 1) && (i == 15));
            end
            n_cmp++; if (busy !== 1'b0 || load_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got busy=%b ready=%b want 0/0", busy, load_ready); end
            n_cmp++; if (load_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", load_count); end
            n_cmp++; if (overflow !== (pass == 0)) begin n_fail++; $display("FAIL ovf_flag pass %0d: got %b want %b", pass, overflow, pass == 0); end
            if (pass == 0) begin
                manual_mode = 0; load_start = 1;
                step();
                load_start = 0;
                n_cmp++; if (busy !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL load_start_run_mode: got busy=%b ovf=%b want 0/1", busy, overflow); end
            end
        end
        for (int a = 0; a < 16; a++) begin
            read_word(a[3:0], d);
            n_cmp++;
            if (d !== ref_mem[a]) begin n_fail++; $display("FAIL ovf_word %0d: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        int cycles;
        start_load();
        send_beat(8'hAA, 1'b0);
        clear_start = 1;
        send_beat(8'hBB, 1'b0);
        clear_start = 0;
        n_cmp++; if (busy !== 1'b1 || load_ready !== 1'b0) begin n_fail++; $display("FAIL abort_to_clear: got busy=%b ready=%b want 1/0", busy, load_ready); end
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            step();
        end
        n_cmp++; if (cycles != 16) begin n_fail++; $display("FAIL abort_busy_cycles: got %0d want 16", cycles); end
        for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
        for (int a = 0; a < 16; a++) begin
            read_word(a[3:0], d);
            n_cmp++;
            if (d !== ref_mem[a]) begin n_fail++; $display("FAIL abort_word %0d: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [7:0] d;
        fill_random();
        clear_start = 1;
        step();
        clear_start = 0;
        repeat (5) step();
        for (int a = 0; a < 5; a++) ref_mem[a] = 8'h00;
        rst = 1;
        step();
        rst = 0;
        n_cmp++; if (busy !== 1'b0 || load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clear: got busy=%b ready=%b want 0/0", busy, load_ready); end
        step();
        for (int a = 0; a < 16; a++) begin
            read_word(a[3:0], d);
            n_cmp++;
            if (d !== ref_mem[a]) begin n_fail++; $display("FAIL rst_clear_word %0d: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
        ref_mem[0] = 8'h58; ref_mem[1] = 8'hE0; ref_mem[2] = 8'h51;
        ref_mem[3] = 8'hE0; ref_mem[4] = 8'h60;
        test_reset();
        test_powerup();
        test_direct_write();
        test_clear();
        fill_random();
        test_load_backpressure();
        test_load_random();
        test_load_overflow();
        test_abort();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
